pipeline_ctrl: RTL

Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Generates the en/flush inputs of reg_if_id, reg_id_ex, reg_ex_mem and reg_mem_wb, plus the PC enable.
- Generates EX-stage forwarding selects.
- Handles load-use stalls, taken-branch squash (branch resolved in MEM), data-memory wait-state handshake with timeout, and debug halt/single-step.

---
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: stage enables,
// bubble flushes, EX forwarding selects, data-memory wait handling and debug halt/step.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_ID,
  input  logic [4:0]       Rs2_ID,
  input  logic [4:0]       Rs1_EX,
  input  logic [4:0]       Rs2_EX,
  input  logic [4:0]       Rd_EX,
  input  logic             RegWrite_EX,
  input  logic [1:0]       ResultSrc_EX,
  input  logic [4:0]       Rd_MEM,
  input  logic             RegWrite_MEM,
  input  logic [4:0]       Rd_WB,
  input  logic             RegWrite_WB,
  input  logic             BranchTaken_MEM,
  input  logic             MemAccess_MEM,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic [1:0]       ForwardA_EX,
  output logic [1:0]       ForwardB_EX,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED, STEP} state_t;

  state_t           r_state, w_nextState;
  logic [15:0]      r_waitCnt, w_nextWaitCnt;
  logic             r_fromStep, w_nextFromStep;
  logic             r_memError, w_nextMemError;
  logic [CNT_W-1:0] r_stallCnt;

  logic w_memBusy;
  logic w_loadUse;

  assign w_memBusy = MemAccess_MEM & ~dmem_ready;
  assign w_loadUse = (ResultSrc_EX == 2'b01) & RegWrite_EX & (Rd_EX != 5'd0) &
                     ((Rd_EX == Rs1_ID) | (Rd_EX == Rs2_ID));

  // MEM-stage ALU result is younger than the WB result, so it wins; x0 is never forwarded.
  assign ForwardA_EX = (RegWrite_MEM && Rd_MEM != 5'd0 && Rd_MEM == Rs1_EX) ? 2'b10 :
                       (RegWrite_WB  && Rd_WB  != 5'd0 && Rd_WB  == Rs1_EX) ? 2'b01 : 2'b00;
  assign ForwardB_EX = (RegWrite_MEM && Rd_MEM != 5'd0 && Rd_MEM == Rs2_EX) ? 2'b10 :
                       (RegWrite_WB  && Rd_WB  != 5'd0 && Rd_WB  == Rs2_EX) ? 2'b01 : 2'b00;

  assign halted    = (r_state == HALTED);
  assign mem_error = r_memError;
  assign stall_cnt = r_stallCnt;

  always_comb begin
    en_pc        = 1'b1;
    en_if_id     = 1'b1;
    en_id_ex     = 1'b1;
    en_ex_mem    = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    // A pending memory access outranks a branch squash, which is replayed once it completes.
    if (r_state == HALTED || w_memBusy) begin
      en_pc        = 1'b0;
      en_if_id     = 1'b0;
      en_id_ex     = 1'b0;
      en_ex_mem    = 1'b0;
      flush_mem_wb = 1'b1;
    end else if (BranchTaken_MEM) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (w_loadUse) begin
      en_pc       = 1'b0;
      en_if_id    = 1'b0;
      flush_id_ex = 1'b1;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextWaitCnt  = r_waitCnt;
    w_nextFromStep = r_fromStep;
    w_nextMemError = r_memError;
    unique case (r_state)
      RUN: begin
        if (w_memBusy) begin
          w_nextState    = MEM_WAIT;
          w_nextWaitCnt  = 16'd1;
          w_nextFromStep = 1'b0;
        end else if (halt_req) begin
          w_nextState = HALTED;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          w_nextState    = (r_fromStep && halt_req) ? HALTED : RUN;
          w_nextWaitCnt  = 16'd0;
          w_nextFromStep = 1'b0;
        end else if (r_waitCnt == 16'(MEM_TIMEOUT)) begin
          w_nextState    = HALTED;
          w_nextMemError = 1'b1;
        end else begin
          w_nextWaitCnt = r_waitCnt + 16'd1;
        end
      end
      HALTED: begin
        if (!r_memError) begin
          if (step_req)       w_nextState = STEP;
          else if (!halt_req) w_nextState = RUN;
        end
      end
      STEP: begin
        if (w_memBusy) begin
          w_nextState    = MEM_WAIT;
          w_nextWaitCnt  = 16'd1;
          w_nextFromStep = 1'b1;
        end else begin
          w_nextState = HALTED;
        end
      end
      default: w_nextState = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= RUN;
      r_waitCnt  <= 16'd0;
      r_fromStep <= 1'b0;
      r_memError <= 1'b0;
      r_stallCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_waitCnt  <= w_nextWaitCnt;
      r_fromStep <= w_nextFromStep;
      r_memError <= w_nextMemError;
      if (!en_pc && r_state != HALTED && r_stallCnt != '1)
        r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

endmodule
